// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back / write-allocate data cache controller.
// One 32-bit word per line; tag/valid/dirty/data storage held internally.
module cache_ctrl_nway #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_resp,
    output logic [31:0]       cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched request; byte offset is dropped at capture
    logic              r_started;
    logic [ADDR_W-3:0] r_line;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [WAY_W-1:0]  r_victim;
    logic              r_used_inv;
    logic [31:0]       r_rdata;

    // Line storage
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [WAY_W-1:0]  r_rr    [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [31:0]       r_data  [SETS][WAYS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_any_inv;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_victim;
    logic              w_victim_dirty;
    logic [31:0]       w_hit_merged;
    logic [31:0]       w_fill_merged;
    logic              w_unused;

    assign w_unused = ^cpu_addr[1:0];
    assign w_idx    = r_line[IDX_W-1:0];
    assign w_tag    = r_line[ADDR_W-3:IDX_W];

    function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
        f_merge = old_w;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) f_merge[8*b +: 8] = new_w[8*b +: 8];
        end
    endfunction

    // Tag compare and lowest-index invalid way search for the latched set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_any_inv = 1'b0;
        w_inv_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][WAY_W'(w)] && (r_tag[w_idx][WAY_W'(w)] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_idx][WAY_W'(w)] && !w_any_inv) begin
                w_any_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
    end

    assign w_victim       = w_any_inv ? w_inv_way : r_rr[w_idx];
    assign w_victim_dirty = !w_any_inv && r_valid[w_idx][r_rr[w_idx]] && r_dirty[w_idx][r_rr[w_idx]];
    assign w_hit_merged   = f_merge(r_data[w_idx][w_hit_way], r_wdata, r_be);
    assign w_fill_merged  = f_merge(mem_rdata, r_wdata, r_we ? r_be : 4'b0000);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cpu_req && cpu_ready) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (w_hit)               w_next = S_RESP;
                else if (w_victim_dirty) w_next = S_WB;
                else                     w_next = S_FILL;
            end
            S_WB:     if (mem_ready) w_next = S_FILL;
            S_FILL:   if (mem_ready) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode; bus fields are pure functions of state so reset drops them at once
    always_comb begin
        // cpu_ready waits for the first edge after reset release
        cpu_ready = (r_state == S_IDLE) && r_started;
        cpu_resp  = (r_state == S_RESP);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[w_idx][r_victim], w_idx, 2'b00};
                mem_wdata = r_data[w_idx][r_victim];
            end
            S_FILL: begin
                mem_req   = 1'b1;
                mem_addr  = {w_tag, w_idx, 2'b00};
            end
            default: ;
        endcase
    end

    assign cpu_rdata = r_rdata;

    // Request capture, valid/dirty/replacement bookkeeping and response data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started  <= 1'b0;
            r_line     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_victim   <= '0;
            r_used_inv <= 1'b0;
            r_rdata    <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            r_started <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req && cpu_ready) begin
                        r_line  <= cpu_addr[ADDR_W-1:2];
                        r_we    <= cpu_we;
                        r_wdata <= cpu_wdata;
                        r_be    <= cpu_be;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_we) begin
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                            r_rdata                   <= w_hit_merged;
                        end else begin
                            r_rdata <= r_data[w_idx][w_hit_way];
                        end
                    end else begin
                        r_victim   <= w_victim;
                        r_used_inv <= w_any_inv;
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= r_we;
                        r_rdata                  <= w_fill_merged;
                        if (!r_used_inv) r_rr[w_idx] <= r_rr[w_idx] + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays; gated by state, which reset forces to IDLE
    always_ff @(posedge clk) begin
        if (r_state == S_LOOKUP && w_hit && r_we) begin
            r_data[w_idx][w_hit_way] <= w_hit_merged;
        end
        if (r_state == S_FILL && mem_ready) begin
            r_tag[w_idx][r_victim]  <= w_tag;
            r_data[w_idx][r_victim] <= w_fill_merged;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed self-checking bench for cache_ctrl_nway (ADDR_W=32, SETS=4, WAYS=2).
module tb_cache_ctrl_nway;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_ready;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic        cpu_resp;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [int unsigned];
    bit          mem_hold = 1'b0;
    int          mem_lat = 3;
    int          mem_cnt = 0;
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [31:0] log_data[$];

    cache_ctrl_nway #(.ADDR_W(32), .SETS(4), .WAYS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {16'hA5A5, a[15:0]};
    endfunction

    // Memory responder: completes each request after mem_lat unstalled cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else if (mem_req && !mem_hold) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    log_data.push_back(mem_wdata);
                end else begin
                    mem_rdata = mem_read(mem_addr);
                    log_data.push_back(mem_rdata);
                end
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_data.delete();
    endtask

    // One CPU transaction; lat counts falling edges from accept until cpu_resp is seen
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output int lat);
        int guard;
        rdata = '0;
        lat   = 0;
        guard = 0;
        @(negedge clk);
        while (!cpu_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!cpu_ready) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout addr=%h: cpu_ready got 0 expected 1", addr);
            return;
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_resp && lat < 300);
        if (!cpu_resp) begin
            n_vec++; n_err++;
            $display("FAIL resp_timeout addr=%h: cpu_resp got 0 expected 1", addr);
            return;
        end
        rdata = cpu_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL rst_cpu_ready: got %b expected 0", cpu_ready); end
        n_vec++; if (cpu_resp !== 1'b0) begin n_err++; $display("FAIL rst_cpu_resp: got %b expected 0", cpu_resp); end
        n_vec++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rst_cpu_rdata: got %h expected 0", cpu_rdata); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b expected 0", cpu_ready); end
        @(posedge clk);
        #1;
        n_vec++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b expected 1", cpu_ready); end
    endtask

    task automatic test_cold_load();
        logic [31:0] rd;
        int lat;
        clear_log();
        do_req(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL cold_rdata: got %h expected deadbeef", rd); end
        n_vec++; if (log_addr.size() !== 1) begin n_err++; $display("FAIL cold_mem_ops: got %0d expected 1", log_addr.size()); end
        else begin
            n_vec++; if (log_addr[0] !== 32'h100 || log_we[0] !== 1'b0) begin
                n_err++; $display("FAIL cold_fill: got addr %h we %b expected addr 100 we 0", log_addr[0], log_we[0]);
            end
        end
    endtask

    task automatic test_hit_reload();
        logic [31:0] rd;
        int lat;
        clear_log();
        do_req(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL hit_rdata: got %h expected deadbeef", rd); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL hit_latency: got %0d expected 2", lat); end
        n_vec++; if (log_addr.size() !== 0) begin n_err++; $display("FAIL hit_mem_ops: got %0d expected 0", log_addr.size()); end
        @(negedge clk);
        n_vec++; if (cpu_resp !== 1'b0) begin n_err++; $display("FAIL resp_pulse_width: got %b expected 0", cpu_resp); end
        n_vec++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rdata_hold: got %h expected deadbeef", cpu_rdata); end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd;
        int lat;
        clear_log();
        do_req(1'b1, 32'h100, 32'h11223344, 4'b0011, rd, lat);
        n_vec++; if (rd !== 32'hDEAD3344) begin n_err++; $display("FAIL store_hit_rdata: got %h expected dead3344", rd); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL store_hit_latency: got %0d expected 2", lat); end
        do_req(1'b0, 32'h101, 32'h0, 4'h0, rd, lat);
        n_vec++; if (rd !== 32'hDEAD3344) begin n_err++; $display("FAIL load_after_store: got %h expected dead3344", rd); end
        n_vec++; if (log_addr.size() !== 0) begin n_err++; $display("FAIL store_hit_mem_ops: got %0d expected 0", log_addr.size()); end
    endtask

    task automatic test_eviction();
        logic [31:0] rd;
        int lat;
        clear_log();
        do_req(1'b0, 32'h200, 32'h0, 4'h0, rd, lat);
        n_vec++; if (rd !== 32'hA5A50200) begin n_err++; $display("FAIL fill200_rdata: got %h expected a5a50200", rd); end
        n_vec++; if (log_addr.size() !== 1 || log_we[0] !== 1'b0) begin n_err++; $display("FAIL fill200_ops: got %0d ops expected 1 read", log_addr.size()); end
        clear_log();
        do_req(1'b0, 32'h300, 32'h0, 4'h0, rd, lat);
        n_vec++; if (rd !== 32'hA5A50300) begin n_err++; $display("FAIL fill300_rdata: got %h expected a5a50300", rd); end
        n_vec++; if (log_addr.size() !== 2) begin n_err++; $display("FAIL evict_dirty_ops: got %0d expected 2", log_addr.size()); end
        else begin
            n_vec++; if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h100 || log_data[0] !== 32'hDEAD3344) begin
                n_err++; $display("FAIL wb_victim: got we %b addr %h data %h expected we 1 addr 100 data dead3344", log_we[0], log_addr[0], log_data[0]);
            end
            n_vec++; if (log_we[1] !== 1'b0 || log_addr[1] !== 32'h300) begin
                n_err++; $display("FAIL fill_after_wb: got we %b addr %h expected we 0 addr 300", log_we[1], log_addr[1]);
            end
        end
        clear_log();
        do_req(1'b0, 32'h400, 32'h0, 4'h0, rd, lat);
        n_vec++; if (rd !== 32'hA5A50400) begin n_err++; $display("FAIL fill400_rdata: got %h expected a5a50400", rd); end
        n_vec++; if (log_addr.size() !== 1) begin n_err++; $display("FAIL evict_clean_ops: got %0d expected 1", log_addr.size()); end
        else begin
            n_vec++; if (log_we[0] !== 1'b0 || log_addr[0] !== 32'h400) begin
                n_err++; $display("FAIL evict_clean_fill: got we %b addr %h expected we 0 addr 400", log_we[0], log_addr[0]);
            end
        end
        clear_log();
        do_req(1'b0, 32'h300, 32'h0, 4'h0, rd, lat);
        n_vec++; if (lat !== 2 || log_addr.size() !== 0) begin
            n_err++; $display("FAIL reload300_hit: got lat %0d ops %0d expected lat 2 ops 0", lat, log_addr.size());
        end
        n_vec++; if (rd !== 32'hA5A50300) begin n_err++; $display("FAIL reload300_rdata: got %h expected a5a50300", rd); end
    endtask

    task automatic test_fill_stall();
        int guard;
        int stall_bad;
        int lat;
        mem_hold = 1'b1;
        clear_log();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500; cpu_wdata = '0; cpu_be = '0;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!mem_req && guard < 50);
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL stall_req_start: got %b expected 1", mem_req); end
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            n_vec++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h500 || cpu_ready !== 1'b0 || cpu_resp !== 1'b0) begin
                n_err++; stall_bad++;
                $display("FAIL stall_hold[%0d]: got req %b we %b addr %h ready %b expected req 1 we 0 addr 500 ready 0", i, mem_req, mem_we, mem_addr, cpu_ready);
            end
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h904; cpu_wdata = 32'hFFFFFFFF; cpu_be = 4'hF;
            @(negedge clk);
        end
        cpu_req = 1'b0;
        #1 mem_hold = 1'b0;
        lat = 0;
        while (!cpu_resp && lat < 100) begin @(negedge clk); lat++; end
        n_vec++; if (cpu_resp !== 1'b1 || cpu_rdata !== 32'hA5A50500) begin
            n_err++; $display("FAIL stall_resp: got resp %b rdata %h expected resp 1 rdata a5a50500", cpu_resp, cpu_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ignored_req_traffic[%0d]: got mem_req %b expected 0", i, mem_req); end
        end
        n_vec++; if (log_addr.size() !== 1) begin n_err++; $display("FAIL stall_ops: got %0d expected 1", log_addr.size()); end
    endtask

    task automatic test_store_miss();
        logic [31:0] rd;
        int lat;
        clear_log();
        do_req(1'b1, 32'h600, 32'hCAFEF00D, 4'b1100, rd, lat);
        n_vec++; if (rd !== 32'hCAFE0600) begin n_err++; $display("FAIL store_miss600_rdata: got %h expected cafe0600", rd); end
        n_vec++; if (log_addr.size() !== 1 || log_we[0] !== 1'b0) begin n_err++; $display("FAIL store_miss600_ops: got %0d ops expected 1 read", log_addr.size()); end
        clear_log();
        do_req(1'b1, 32'h700, 32'h12345678, 4'b1111, rd, lat);
        n_vec++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL store_miss700_rdata: got %h expected 12345678", rd); end
        n_vec++; if (log_addr.size() !== 1 || log_we[0] !== 1'b0) begin n_err++; $display("FAIL store_miss700_ops: got %0d ops expected 1 read", log_addr.size()); end
    endtask

    task automatic test_reset_mid_wb();
        logic [31:0] rd;
        int lat;
        int guard;
        int bad;
        mem_hold = 1'b1;
        clear_log();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h800; cpu_wdata = '0; cpu_be = '0;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(mem_req && mem_we) && guard < 50);
        n_vec++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h600 || mem_wdata !== 32'hCAFE0600) begin
            n_err++; $display("FAIL wb_bus: got req %b we %b addr %h data %h expected 1 1 600 cafe0600", mem_req, mem_we, mem_addr, mem_wdata);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || cpu_ready !== 1'b0) begin
            n_err++; $display("FAIL async_abort: got req %b addr %h ready %b expected 0 0 0", mem_req, mem_addr, cpu_ready);
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        mem_hold = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_resp !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL post_reset_quiet: got %0d busy cycles expected 0", bad); end
        n_vec++; if (log_addr.size() !== 0) begin n_err++; $display("FAIL aborted_wb_ops: got %0d expected 0", log_addr.size()); end
        clear_log();
        do_req(1'b0, 32'h300, 32'h0, 4'h0, rd, lat);
        n_vec++; if (log_addr.size() !== 1) begin n_err++; $display("FAIL post_reset_miss_ops: got %0d expected 1", log_addr.size()); end
        else begin
            n_vec++; if (log_we[0] !== 1'b0 || log_addr[0] !== 32'h300) begin
                n_err++; $display("FAIL post_reset_fill: got we %b addr %h expected we 0 addr 300", log_we[0], log_addr[0]);
            end
        end
        n_vec++; if (rd !== 32'hA5A50300) begin n_err++; $display("FAIL post_reset_rdata: got %h expected a5a50300", rd); end
    endtask

    task automatic test_other_set();
        logic [31:0] rd;
        int lat;
        clear_log();
        do_req(1'b0, 32'h304, 32'h0, 4'h0, rd, lat);
        n_vec++; if (rd !== 32'hA5A50304) begin n_err++; $display("FAIL set1_fill_rdata: got %h expected a5a50304", rd); end
        do_req(1'b1, 32'h304, 32'hFFFFFFFF, 4'b0000, rd, lat);
        n_vec++; if (rd !== 32'hA5A50304 || lat !== 2) begin
            n_err++; $display("FAIL be0_store: got rdata %h lat %0d expected a5a50304 2", rd, lat);
        end
        do_req(1'b0, 32'h314, 32'h0, 4'h0, rd, lat);
        clear_log();
        do_req(1'b0, 32'h324, 32'h0, 4'h0, rd, lat);
        n_vec++; if (rd !== 32'hA5A50324) begin n_err++; $display("FAIL set1_evict_rdata: got %h expected a5a50324", rd); end
        n_vec++; if (log_addr.size() !== 2) begin n_err++; $display("FAIL be0_dirty_ops: got %0d expected 2", log_addr.size()); end
        else begin
            n_vec++; if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h304 || log_data[0] !== 32'hA5A50304) begin
                n_err++; $display("FAIL be0_wb: got we %b addr %h data %h expected 1 304 a5a50304", log_we[0], log_addr[0], log_data[0]);
            end
        end
    endtask

    initial begin
        mem[32'h100] = 32'hDEADBEEF;
        test_reset();
        test_cold_load();
        test_hit_reload();
        test_store_hit();
        test_eviction();
        test_fill_stall();
        test_store_miss();
        test_reset_mid_wb();
        test_other_set();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
